ov7670_config_sequencer: RTL and testbench

OV7670_CONFIG_SEQUENCER -- requirements
Module: ov7670_config_sequencer

---
 rtl/ov7670_config_sequencer.sv | 144 ++++++++++++++
 tb/tb_ov7670_config_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer.sv
// Walks a {reg_addr, reg_value} settings table and issues one SCCB write per entry.
// Entry 16'hFFF0 inserts a DELAY_CYCLES wait; 16'hFFFF ends the table.
//   state    | meaning
//   IDLE     | waiting for start_i after reset
//   FETCH    | table address presented, ROM settling
//   DECODE   | entry captured and classified
//   ISSUE    | waiting for SCCB ready, then one-cycle write request
//   WAIT_ACK | write in flight, waiting for done/nack
//   DELAY    | counting down a delay entry
//   DONE     | table finished, done_o held
//   ERROR    | retries exhausted, error_o held
module ov7670_config_sequencer #(
  parameter int DELAY_CYCLES = 270000,
  parameter int MAX_RETRIES  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  input  logic        sccb_ready_i,
  output logic        sccb_start_o,
  output logic [7:0]  sccb_reg_o,
  output logic [7:0]  sccb_data_o,
  input  logic        sccb_done_i,
  input  logic        sccb_nack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_ACK, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     addr_d;
  logic [15:0]    entry_q, entry_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           done_d, error_d;
  logic           advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rom_addr_o <= '0;
      entry_q    <= '0;
      retry_q    <= '0;
      cnt_q      <= '0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_o <= addr_d;
      entry_q    <= entry_d;
      retry_q    <= retry_d;
      cnt_q      <= cnt_d;
      done_o     <= done_d;
      error_o    <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = rom_addr_o;
    entry_d      = entry_q;
    retry_d      = retry_q;
    cnt_d        = cnt_q;
    done_d       = done_o;
    error_d      = error_o;
    sccb_start_o = 1'b0;
    advance      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          addr_d  = '0;
          retry_d = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        entry_d = rom_data_i;
        if (rom_data_i == 16'hFFFF) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (rom_data_i == 16'hFFF0) begin
          cnt_d   = CW'(DELAY_CYCLES - 1);
          state_d = S_DELAY;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (sccb_ready_i) begin
          sccb_start_o = 1'b1;
          state_d      = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (sccb_done_i) begin
          if (!sccb_nack_i) begin
            retry_d = '0;
            advance = 1'b1;
          end else if (retry_q < RW'(MAX_RETRIES)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        end
      end
      // Counter starts at DELAY_CYCLES-1 so the state lasts exactly DELAY_CYCLES cycles.
      S_DELAY: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The last table slot finishes the run instead of wrapping back to entry 0.
    if (advance) begin
      if (rom_addr_o == 8'hFF) begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end else begin
        addr_d  = rom_addr_o + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  assign sccb_reg_o  = entry_q[15:8];
  assign sccb_data_o = entry_q[7:0];
  assign busy_o      = !(state_q inside {S_IDLE, S_DONE, S_ERROR});

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Self-checking bench: a settings-table ROM, an SCCB responder and a reference model
// that predicts the write list, the cycle gaps between writes and the final outcome.
module tb_ov7670_config_sequencer;

  localparam int DELAY_CYCLES = 8;
  localparam int MAX_RETRIES  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [7:0]  rom_addr_o;
  logic [15:0] rom_data_i;
  logic        sccb_ready_i;
  logic        sccb_start_o;
  logic [7:0]  sccb_reg_o;
  logic [7:0]  sccb_data_o;
  logic        sccb_done_i;
  logic        sccb_nack_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  logic [15:0] rom [256];
  assign rom_data_i = rom[rom_addr_o];

  ov7670_config_sequencer #(.DELAY_CYCLES(DELAY_CYCLES), .MAX_RETRIES(MAX_RETRIES)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i), .sccb_ready_i(sccb_ready_i), .sccb_start_o(sccb_start_o),
    .sccb_reg_o(sccb_reg_o), .sccb_data_o(sccb_data_o), .sccb_done_i(sccb_done_i),
    .sccb_nack_i(sccb_nack_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  bit          nack_plan[$];
  logic [15:0] exp_w[$];
  int          exp_gap[$];
  bit          exp_done, exp_err;
  logic [7:0]  exp_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  // Walks the table the way the camera setup is described: writes, retries, delays,
  // terminator, last-slot stop. Gap = cycles from start/ack (or nack) to the next request.
  task automatic build_model();
    int a = 0, ti = 0, ndly = 0, tries;
    bit after_nack = 1'b0;
    logic [15:0] e;
    exp_w.delete(); exp_gap.delete();
    exp_done = 1'b0; exp_err = 1'b0;
    forever begin
      e = rom[a];
      if (e == 16'hFFFF) begin exp_done = 1'b1; break; end
      if (e == 16'hFFF0) ndly++;
      else begin
        tries = 0;
        forever begin
          exp_w.push_back(e);
          exp_gap.push_back(after_nack ? 1 : 3 + ndly * (DELAY_CYCLES + 2));
          ndly = 0;
          after_nack = (ti < nack_plan.size()) ? nack_plan[ti] : 1'b0;
          ti++;
          if (!after_nack) break;
          tries++;
          if (tries > MAX_RETRIES) begin exp_err = 1'b1; break; end
        end
        if (exp_err) break;
      end
      if (a == 255) begin exp_done = 1'b1; break; end
      a++;
    end
    exp_addr = 8'(a);
  endtask

  task automatic run_table(input bit rnd_ready, input int ready_low_until, input int stray1,
                           input int stray2, input bit stray_done, input int budget);
    int cyc = 0, done_at = -1, last_ev = 0, wi = 0, ti = 0, first_cyc = -1;
    bit pend_nack = 1'b0, fin = 1'b0, busy_now;
    logic [15:0] cur = '0;
    build_model();
    while (!fin && cyc < budget) begin
      @(negedge clk);
      busy_now = busy_o;
      start_i = (cyc == 0) || (busy_now && (cyc == stray1 || cyc == stray2));
      sccb_ready_i = (cyc < ready_low_until) ? 1'b0 :
                     (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      sccb_done_i = 1'b0;
      sccb_nack_i = 1'b0;
      if (cyc == done_at) begin
        sccb_done_i = 1'b1;
        sccb_nack_i = pend_nack;
        done_at = -1;
        last_ev = cyc;
      end else if (stray_done && done_at < 0 && $urandom_range(0, 7) == 0) begin
        sccb_done_i = 1'b1;
        sccb_nack_i = 1'($urandom_range(0, 1));
      end
      #1;
      if (sccb_start_o === 1'b1) begin
        check("start_needs_ready", sccb_ready_i, 1);
        check("write_in_range", wi < exp_w.size(), 1);
        if (wi < exp_w.size()) begin
          check("write", {sccb_reg_o, sccb_data_o}, exp_w[wi]);
          if (!rnd_ready && ready_low_until == 0) check("gap", cyc - last_ev, exp_gap[wi]);
        end
        if (first_cyc < 0) first_cyc = cyc;
        cur = {sccb_reg_o, sccb_data_o};
        pend_nack = (ti < nack_plan.size()) ? nack_plan[ti] : 1'b0;
        ti++;
        wi++;
        done_at = cyc + $urandom_range(1, 5);
      end else if (done_at >= 0) begin
        check("hold_reg_data", {sccb_reg_o, sccb_data_o}, cur);
      end
      if (cyc > 0 && (done_o === 1'b1 || error_o === 1'b1)) fin = 1'b1;
      cyc++;
    end
    check("finished", fin, 1);
    check("write_count", wi, exp_w.size());
    if (ready_low_until > 0) check("ready_wait", first_cyc, ready_low_until);
    check("done_o", done_o, exp_done);
    check("error_o", error_o, exp_err);
    check("busy_o_end", busy_o, 0);
    check("rom_addr_o_end", rom_addr_o, exp_addr);
    @(negedge clk);
    start_i = 1'b0; sccb_done_i = 1'b0; sccb_nack_i = 1'b0; sccb_ready_i = 1'b1;
  endtask

  initial begin
    int seen, nst, n;
    logic [15:0] v;
    reset = 1'b1; start_i = 1'b0; sccb_ready_i = 1'b1; sccb_done_i = 1'b0; sccb_nack_i = 1'b0;
    fill_rom();
    @(negedge clk); @(negedge clk); #1;
    check("reset_outputs", {rom_addr_o, sccb_start_o, sccb_reg_o, sccb_data_o, busy_o, done_o, error_o}, 0);
    @(negedge clk); reset = 1'b0;

    // Delay entry between two writes
    fill_rom(); rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1204;
    nack_plan.delete();
    run_table(1'b0, 0, -1, -1, 1'b0, 500);

    // Two NACKs then ACK on the first entry
    fill_rom(); rom[0] = 16'h1280; rom[1] = 16'h1204;
    nack_plan = '{1'b1, 1'b1, 1'b0};
    run_table(1'b0, 0, -1, -1, 1'b0, 500);

    // Four NACKs exhaust retries, then a fresh start runs from entry 0
    nack_plan = '{1'b1, 1'b1, 1'b1, 1'b1};
    run_table(1'b0, 0, -1, -1, 1'b0, 500);
    nack_plan.delete();
    run_table(1'b0, 0, -1, -1, 1'b0, 500);

    // Ready held low through ISSUE, stray starts mid-run, FFxx written as a normal register
    fill_rom(); rom[0] = 16'h1280; rom[1] = 16'hFF12; rom[2] = 16'h1204; rom[3] = 16'h1311;
    rom[4] = 16'h1422;
    run_table(1'b0, 23, 10, 40, 1'b0, 500);

    // Full 256-entry table with no terminator
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      if (v[15:4] == 12'hFFF) v = 16'h3A5C;
      rom[i] = v;
    end
    run_table(1'b0, 0, -1, -1, 1'b0, 4000);

    // Reset while a write is in flight; a late done must be ignored
    fill_rom(); rom[0] = 16'h1280; rom[1] = 16'h1204;
    @(negedge clk); start_i = 1'b1; sccb_ready_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk); #1;
      if (sccb_start_o === 1'b1) seen = 1;
    end
    check("rst_reached_issue", seen, 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b1; #1;
    check("rst_mid_outputs", {rom_addr_o, sccb_start_o, sccb_reg_o, sccb_data_o, busy_o, done_o, error_o}, 0);
    @(negedge clk); reset = 1'b0; sccb_done_i = 1'b1;
    @(negedge clk); sccb_done_i = 1'b0;
    nst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (sccb_start_o === 1'b1) nst++;
    end
    check("rst_no_new_request", nst, 0);
    check("rst_idle", {busy_o, done_o, error_o, rom_addr_o}, 0);

    // Randomised tables, NACKs, ready stalls, stray done and start pulses
    for (int t = 0; t < 8; t++) begin
      fill_rom();
      n = $urandom_range(2, 12);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 5))
          0: v = 16'hFFF0;
          1: begin v = {8'hFF, 8'($urandom_range(0, 8'hEF))}; end
          default: begin
            v = 16'($urandom);
            if (v[15:4] == 12'hFFF) v = 16'h1111;
          end
        endcase
        rom[i] = v;
      end
      nack_plan.delete();
      for (int i = 0; i < 80; i++) nack_plan.push_back($urandom_range(0, 3) == 0);
      run_table(1'(t % 2), 0, $urandom_range(5, 60), $urandom_range(61, 150), 1'b1, 3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
